// File: rtl/pp_loop_monitor.sv
// ============================================================================
// Module      : pp_loop_monitor
// Description : Performance monitor for one pipelined loop of an HLS FSM.
//               Detects loop entry/exit from the one-hot state vector,
//               counts activations and retired iterations, tracks iterations
//               in flight and measures per-activation latency. All counters
//               saturate at their maximum value.
//               Optional feature macro: PP_LOOP_II_STATS_EN adds min/max
//               initiation-interval statistics; without it min_ii/max_ii = 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_loop_monitor #(
  parameter int STATE_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state0,
  input  logic               pre_states_valid,
  input  logic [STATE_W-1:0] post_loop_state0,
  input  logic               post_states_valid,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic               iter_start_enable,
  input  logic               iter_start_block,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_end_enable,
  input  logic               iter_end_block,
  input  logic [STATE_W-1:0] loop_quit_state,
  input  logic               quit_at_end,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_count,
  output logic [CNT_W-1:0]   iter_count,
  output logic [CNT_W-1:0]   inflight,
  output logic [CNT_W-1:0]   last_latency,
  output logic [CNT_W-1:0]   max_latency,
  output logic               err_flag,
  output logic               stats_frozen,
  output logic [CNT_W-1:0]   min_ii,
  output logic [CNT_W-1:0]   max_ii
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Saturating increment shared by every counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + c_cnt_one);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STATE_W-1:0] r_prev_state;
  logic               w_start_ev;
  logic               w_end_ev;
  logic               w_enter;
  logic               w_exit;
  logic               w_freeze;

  logic [CNT_W-1:0]   r_loop_count;
  logic [CNT_W-1:0]   r_iter_count;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_latency;
  logic [CNT_W-1:0]   r_last_latency;
  logic [CNT_W-1:0]   r_max_latency;
  logic               r_err;
  logic               r_frozen;

  // Iteration issue/retire events, qualified by the stage enables and blocks.
  assign w_start_ev = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
  assign w_end_ev   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;

  // The cycle finish is sampled already holds everything.
  assign w_freeze   = finish | r_frozen;

  // Registered copy of the kernel state for edge-style entry/exit detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_state <= '0;
    end else begin
      r_prev_state <= cur_state;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: entry on pre->start transition, exit on quit->post.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    if (!w_freeze) begin
      case (r_state)
        ST_IDLE: begin
          if (pre_states_valid && (r_prev_state == pre_loop_state0) &&
              (cur_state == iter_start_state)) begin
            w_state_nxt = ST_ACTIVE;
            w_enter     = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (post_states_valid && (r_prev_state == loop_quit_state) &&
              (cur_state == post_loop_state0)) begin
            w_state_nxt = ST_IDLE;
            w_exit      = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Statistics counters. The entry cycle counts its own issue so that the
  // first iteration of the pipeline is in flight when it later retires.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_loop_count   <= '0;
      r_iter_count   <= '0;
      r_inflight     <= '0;
      r_latency      <= '0;
      r_last_latency <= '0;
      r_max_latency  <= '0;
      r_err          <= 1'b0;
    end else if (!w_freeze) begin
      if (w_enter) begin
        r_latency  <= c_cnt_one;
        r_inflight <= w_start_ev ? c_cnt_one : '0;
      end else if (r_state == ST_ACTIVE) begin
        if (w_exit) begin
          // Latency excludes the post-state cycle.
          r_last_latency <= r_latency;
          if (r_latency > r_max_latency) begin
            r_max_latency <= r_latency;
          end
          r_loop_count <= sat_inc(r_loop_count);
          if (quit_at_end) begin
            if (r_inflight != '0) begin
              r_err <= 1'b1;
            end
          end else begin
            r_inflight <= '0;
          end
        end else begin
          r_latency <= sat_inc(r_latency);
          if (w_end_ev) begin
            r_iter_count <= sat_inc(r_iter_count);
          end
          case ({w_start_ev, w_end_ev})
            2'b10: r_inflight <= sat_inc(r_inflight);
            2'b01: begin
              // Retire with nothing in flight is a protocol error.
              if (r_inflight == '0) begin
                r_err <= 1'b1;
              end else begin
                r_inflight <= r_inflight - c_cnt_one;
              end
            end
            default: r_inflight <= r_inflight;
          endcase
        end
      end
    end
  end

  // Sticky freeze flag, released only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frozen <= 1'b0;
    end else if (finish) begin
      r_frozen <= 1'b1;
    end
  end

`ifdef PP_LOOP_II_STATS_EN
  logic [CNT_W-1:0] r_ii_cnt;
  logic             r_ii_armed;
  logic [CNT_W-1:0] r_min_ii;
  logic [CNT_W-1:0] r_max_ii;
  logic [CNT_W-1:0] w_ii_interval;

  // Distance from the previous issue, counting the current cycle.
  assign w_ii_interval = sat_inc(r_ii_cnt);

  // Initiation-interval tracker; the first issue of an activation only arms it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ii_cnt   <= '0;
      r_ii_armed <= 1'b0;
      r_min_ii   <= '1;
      r_max_ii   <= '0;
    end else if (!w_freeze) begin
      if (w_enter) begin
        r_ii_armed <= w_start_ev;
        r_ii_cnt   <= '0;
      end else if (r_state == ST_ACTIVE) begin
        if (w_exit) begin
          r_ii_armed <= 1'b0;
          r_ii_cnt   <= '0;
        end else if (w_start_ev) begin
          if (r_ii_armed) begin
            if (w_ii_interval < r_min_ii) begin
              r_min_ii <= w_ii_interval;
            end
            if (w_ii_interval > r_max_ii) begin
              r_max_ii <= w_ii_interval;
            end
          end
          r_ii_armed <= 1'b1;
          r_ii_cnt   <= '0;
        end else begin
          r_ii_cnt <= sat_inc(r_ii_cnt);
        end
      end
    end
  end

  assign min_ii = r_min_ii;
  assign max_ii = r_max_ii;
`else
  assign min_ii = '0;
  assign max_ii = '0;
`endif

  assign loop_active  = (r_state == ST_ACTIVE);
  assign loop_count   = r_loop_count;
  assign iter_count   = r_iter_count;
  assign inflight     = r_inflight;
  assign last_latency = r_last_latency;
  assign max_latency  = r_max_latency;
  assign err_flag     = r_err;
  assign stats_frozen = r_frozen;

endmodule

`default_nettype wire

// File: tb/tb_pp_loop_monitor.sv
// ============================================================================
// Module      : tb_pp_loop_monitor
// Description : Directed, table-driven bench for pp_loop_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_loop_monitor;

  localparam logic [15:0] c_idle = 16'h0008;
  localparam logic [15:0] c_pre  = 16'h0001;
  localparam logic [15:0] c_loop = 16'h0002;
  localparam logic [15:0] c_post = 16'h0004;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b0;
  logic [15:0] cur_state = '0;
  logic [15:0] pre_loop_state0 = c_pre;
  logic        pre_states_valid = 1'b1;
  logic [15:0] post_loop_state0 = c_post;
  logic        post_states_valid = 1'b1;
  logic [15:0] iter_start_state = c_loop;
  logic        iter_start_enable = 1'b0;
  logic        iter_start_block = 1'b0;
  logic [15:0] iter_end_state = c_loop;
  logic        iter_end_enable = 1'b0;
  logic        iter_end_block = 1'b0;
  logic [15:0] loop_quit_state = c_loop;
  logic        quit_at_end = 1'b1;
  logic        loop_active;
  logic [31:0] loop_count, iter_count, inflight, last_latency, max_latency;
  logic        err_flag, stats_frozen;
  logic [31:0] min_ii, max_ii;

  int n_checks = 0;
  int n_err = 0;

  pp_loop_monitor #(.STATE_W(16), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .finish(finish), .cur_state(cur_state),
    .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
    .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
    .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
    .loop_active(loop_active), .loop_count(loop_count), .iter_count(iter_count),
    .inflight(inflight), .last_latency(last_latency), .max_latency(max_latency),
    .err_flag(err_flag), .stats_frozen(stats_frozen), .min_ii(min_ii), .max_ii(max_ii)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] cur;
    logic        sen;
    logic        een;
    logic [31:0] e_active;
    logic [31:0] e_loop;
    logic [31:0] e_iter;
    logic [31:0] e_infl;
    logic [31:0] e_last;
    logic [31:0] e_max;
    logic [31:0] e_err;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [15:0] cs, input logic sen, input logic sblk,
                       input logic een, input logic eblk, input logic fin);
    @(negedge clock);
    cur_state         = cs;
    iter_start_enable = sen;
    iter_start_block  = sblk;
    iter_end_enable   = een;
    iter_end_block    = eblk;
    finish            = fin;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    cur_state = c_idle; iter_start_enable = 0; iter_start_block = 0;
    iter_end_enable = 0; iter_end_block = 0; finish = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One activation: n issues, optional stall of stall_len cycles after stall_after
  // issues, retire one cycle after issue, one drain cycle, then the post state.
  task automatic run_loop(input int n, input int stall_after, input int stall_len);
    int issued = 0;
    int stalled = 0;
    logic prev_started = 1'b0;
    logic started;
    drive(c_pre, 0, 0, 0, 0, 0);
    while (issued < n || prev_started) begin
      started = 1'b0;
      if (issued < n) begin
        if (issued == stall_after && stalled < stall_len) begin
          stalled++;
          drive(c_loop, 1, 1, prev_started, 0, 0);
        end else begin
          issued++;
          started = 1'b1;
          drive(c_loop, 1, 0, prev_started, 0, 0);
        end
      end else begin
        drive(c_loop, 0, 0, prev_started, 0, 0);
      end
      prev_started = started;
    end
    drive(c_post, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Basic loop vector table: 8 issues at II=1, retire one cycle later.
    tbl[0]  = '{c_idle, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[1]  = '{c_pre,  1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[2]  = '{c_loop, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int k = 3; k <= 9; k++) begin
      tbl[k] = '{c_loop, 1'b1, 1'b1, 32'd1, 32'd0, 32'(k - 2), 32'd1, 32'd0, 32'd0, 32'd0};
    end
    tbl[10] = '{c_loop, 1'b0, 1'b1, 32'd1, 32'd0, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[11] = '{c_post, 1'b0, 1'b0, 32'd0, 32'd1, 32'd8, 32'd0, 32'd9, 32'd9, 32'd0};

    // T1: reset with random inputs.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      cur_state = 16'($urandom); iter_start_enable = 1'($urandom);
      iter_start_block = 1'($urandom); iter_end_enable = 1'($urandom);
      iter_end_block = 1'($urandom); finish = 1'($urandom); quit_at_end = 1'($urandom);
    end
    @(posedge clock); #1;
    check("rst.active", {31'd0, loop_active}, 32'd0);
    check("rst.loop_count", loop_count, 32'd0);
    check("rst.iter_count", iter_count, 32'd0);
    check("rst.inflight", inflight, 32'd0);
    check("rst.last_latency", last_latency, 32'd0);
    check("rst.max_latency", max_latency, 32'd0);
    check("rst.err", {31'd0, err_flag}, 32'd0);
    check("rst.frozen", {31'd0, stats_frozen}, 32'd0);
`ifdef PP_LOOP_II_STATS_EN
    check("rst.min_ii", min_ii, 32'hFFFF_FFFF);
`else
    check("rst.min_ii", min_ii, 32'd0);
`endif
    check("rst.max_ii", max_ii, 32'd0);
    quit_at_end = 1'b1;
    do_reset();

    // T2: basic loop from the table.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].cur, tbl[i].sen, 0, tbl[i].een, 0, 0);
      check($sformatf("t2[%0d].active", i), {31'd0, loop_active}, tbl[i].e_active);
      check($sformatf("t2[%0d].loop", i), loop_count, tbl[i].e_loop);
      check($sformatf("t2[%0d].iter", i), iter_count, tbl[i].e_iter);
      check($sformatf("t2[%0d].inflight", i), inflight, tbl[i].e_infl);
      check($sformatf("t2[%0d].last", i), last_latency, tbl[i].e_last);
      check($sformatf("t2[%0d].max", i), max_latency, tbl[i].e_max);
      check($sformatf("t2[%0d].err", i), {31'd0, err_flag}, tbl[i].e_err);
    end
`ifdef PP_LOOP_II_STATS_EN
    check("t2.min_ii", min_ii, 32'd1);
    check("t2.max_ii", max_ii, 32'd1);
`endif

    // T3: same loop with a 3-cycle issue stall after the 4th issue.
    run_loop(8, 4, 3);
    check("t3.last", last_latency, 32'd12);
    check("t3.iter", iter_count, 32'd16);
    check("t3.loop", loop_count, 32'd2);
    check("t3.inflight", inflight, 32'd0);
    check("t3.err", {31'd0, err_flag}, 32'd0);
`ifdef PP_LOOP_II_STATS_EN
    check("t3.min_ii", min_ii, 32'd1);
    check("t3.max_ii", max_ii, 32'd4);
`endif

    // T4: two activations, latencies 9 then 5.
    do_reset();
    run_loop(8, 0, 0);
    check("t4.last1", last_latency, 32'd9);
    run_loop(4, 0, 0);
    check("t4.loop", loop_count, 32'd2);
    check("t4.last2", last_latency, 32'd5);
    check("t4.max", max_latency, 32'd9);
    check("t4.iter", iter_count, 32'd12);

    // T5a: retire with nothing in flight.
    do_reset();
    drive(c_pre, 0, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 0, 0, 1, 0, 0);
    check("t5a.err_before", {31'd0, err_flag}, 32'd0);
    drive(c_loop, 0, 0, 1, 0, 0);
    check("t5a.err", {31'd0, err_flag}, 32'd1);
    check("t5a.inflight", inflight, 32'd0);
    drive(c_post, 0, 0, 0, 0, 0);
    check("t5a.err_sticky", {31'd0, err_flag}, 32'd1);

    // T5b: non-drained exit with quit_at_end=1.
    do_reset();
    drive(c_pre, 0, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 0, 0, 0, 0, 0);
    check("t5b.inflight", inflight, 32'd2);
    drive(c_post, 0, 0, 0, 0, 0);
    check("t5b.err", {31'd0, err_flag}, 32'd1);
    check("t5b.loop", loop_count, 32'd1);

    // T5c: early exit with quit_at_end=0 flushes in-flight count.
    do_reset();
    quit_at_end = 1'b0;
    drive(c_pre, 0, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 0, 0, 0, 0, 0);
    check("t5c.inflight_before", inflight, 32'd2);
    drive(c_post, 0, 0, 0, 0, 0);
    check("t5c.inflight", inflight, 32'd0);
    check("t5c.err", {31'd0, err_flag}, 32'd0);
    check("t5c.loop", loop_count, 32'd1);
    quit_at_end = 1'b1;

    // T6: finish mid-loop freezes everything until reset.
    do_reset();
    drive(c_pre, 0, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 0, 0, 0);
    drive(c_loop, 1, 0, 1, 0, 0);
    drive(c_loop, 1, 0, 1, 0, 1);
    check("t6.frozen", {31'd0, stats_frozen}, 32'd1);
    check("t6.iter_at_finish", iter_count, 32'd1);
    drive(c_loop, 1, 0, 1, 0, 0);
    drive(c_loop, 0, 0, 1, 0, 0);
    drive(c_post, 0, 0, 0, 0, 0);
    check("t6.iter_hold", iter_count, 32'd1);
    check("t6.inflight_hold", inflight, 32'd1);
    check("t6.loop_hold", loop_count, 32'd0);
    check("t6.active_hold", {31'd0, loop_active}, 32'd1);
    check("t6.frozen_hold", {31'd0, stats_frozen}, 32'd1);
    do_reset();
    #1;
    check("t6.frozen_cleared", {31'd0, stats_frozen}, 32'd0);
    check("t6.active_cleared", {31'd0, loop_active}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
